// File: rtl/axon_sched.sv
// Two-requester input scheduler for the axon slide engine: per-input FIFOs,
// packet-level round-robin, atomic DATA bursts and WRITE/READ diversion to cfg.
module axon_sched #(
    parameter int unsigned SW    = 24,
    parameter int unsigned FTW   = 3,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in0_vld,
    output logic           in0_rdy,
    input  logic [SW-1:0]  in0_data,
    input  logic [FTW-1:0] in0_type,
    input  logic           in1_vld,
    output logic           in1_rdy,
    input  logic [SW-1:0]  in1_data,
    input  logic [FTW-1:0] in1_type,
    input  logic           axon_busy,
    output logic           spk_in_axon_vld,
    output logic [SW-1:0]  spk_in_axon_data,
    output logic [FTW-1:0] spk_in_axon_type,
    output logic           cfg_vld,
    output logic [SW-1:0]  cfg_data,
    output logic [FTW-1:0] cfg_type,
    output logic           sched_err,
    output logic [CW-1:0]  spk_cnt,
    output logic           sched_idle
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [FTW-1:0] T_SPIKE = FTW'(0);
    localparam logic [FTW-1:0] T_DATA  = FTW'(1);
    localparam logic [FTW-1:0] T_END   = FTW'(2);
    localparam logic [FTW-1:0] T_WRITE = FTW'(6);
    localparam logic [FTW-1:0] T_READ  = FTW'(7);

    typedef enum logic {ST_ARB = 1'b0, ST_BURST = 1'b1} state_t;

    function automatic logic is_cfg(input logic [FTW-1:0] t);
        return (t == T_WRITE) || (t == T_READ);
    endfunction

    function automatic logic is_axon(input logic [FTW-1:0] t);
        return (t == T_SPIKE) || (t == T_DATA);
    endfunction

    logic [1:0]     in_vld;
    logic [SW-1:0]  in_data [2];
    logic [FTW-1:0] in_type [2];

    assign in_vld     = {in1_vld, in0_vld};
    assign in_data[0] = in0_data;
    assign in_data[1] = in1_data;
    assign in_type[0] = in0_type;
    assign in_type[1] = in1_type;

    logic [SW-1:0]  dmem_q [2][DEPTH];
    logic [FTW-1:0] tmem_q [2][DEPTH];
    logic [PW-1:0]  wr_q [2];
    logic [PW-1:0]  rd_q [2];
    logic [PW-1:0]  wr_d [2];
    logic [PW-1:0]  rd_d [2];

    logic [1:0]     empty, full, rdy, push;
    logic [SW-1:0]  head_data [2];
    logic [FTW-1:0] head_type [2];

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic           rr_q, rr_d;
    logic           g, pop;
    logic           ax_vld_q, ax_vld_d, cfg_vld_q, cfg_vld_d;
    logic [SW-1:0]  ax_data_q, ax_data_d, cfg_data_q, cfg_data_d;
    logic [FTW-1:0] ax_type_q, ax_type_d, cfg_type_q, cfg_type_d;
    logic           err_q, err_d, idle_q, idle_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // FIFO status and head peek
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            empty[i]     = (wr_q[i] == rd_q[i]);
            full[i]      = (wr_q[i][AW] != rd_q[i][AW]) && (wr_q[i][AW-1:0] == rd_q[i][AW-1:0]);
            rdy[i]       = !rst && !full[i];
            push[i]      = in_vld[i] && rdy[i];
            head_data[i] = dmem_q[i][rd_q[i][AW-1:0]];
            head_type[i] = tmem_q[i][rd_q[i][AW-1:0]];
        end
    end

    assign in0_rdy = rdy[0];
    assign in1_rdy = rdy[1];

    // Grant: burst owner, else round-robin; a busy-blocked axon head yields to a cfg head
    always_comb begin
        g = 1'b0;
        if (state_q == ST_BURST) begin
            g = owner_q;
        end else begin
            if (!empty[0] && !empty[1]) g = ~rr_q;
            else                        g = empty[0];
            if (is_axon(head_type[g]) && axon_busy && !empty[~g] && is_cfg(head_type[~g]))
                g = ~g;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        pop        = 1'b0;
        ax_vld_d   = 1'b0;
        ax_data_d  = ax_data_q;
        ax_type_d  = ax_type_q;
        cfg_vld_d  = 1'b0;
        cfg_data_d = cfg_data_q;
        cfg_type_d = cfg_type_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        if (!empty[g]) begin
            if (state_q == ST_ARB) begin
                if (head_type[g] == T_SPIKE) begin
                    if (!axon_busy) begin
                        pop       = 1'b1;
                        ax_vld_d  = 1'b1;
                        ax_data_d = head_data[g];
                        ax_type_d = head_type[g];
                        if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
                    end
                end else if (head_type[g] == T_DATA) begin
                    if (!axon_busy) begin
                        pop       = 1'b1;
                        ax_vld_d  = 1'b1;
                        ax_data_d = head_data[g];
                        ax_type_d = head_type[g];
                        state_d   = ST_BURST;
                        owner_d   = g;
                    end
                end else if (is_cfg(head_type[g])) begin
                    pop        = 1'b1;
                    cfg_vld_d  = 1'b1;
                    cfg_data_d = head_data[g];
                    cfg_type_d = head_type[g];
                end else begin
                    pop   = 1'b1;
                    err_d = 1'b1;
                end
            end else begin
                pop = 1'b1;
                if ((head_type[g] == T_DATA) || (head_type[g] == T_END)) begin
                    ax_vld_d  = 1'b1;
                    ax_data_d = head_data[g];
                    ax_type_d = head_type[g];
                    if (head_type[g] == T_END) state_d = ST_ARB;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
        if (pop) rr_d = g;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wr_d[i] = wr_q[i] + PW'(push[i]);
            rd_d[i] = rd_q[i] + PW'(pop && (g == 1'(i)));
        end
        idle_d = (wr_d[0] == rd_d[0]) && (wr_d[1] == rd_d[1]) &&
                 (state_d == ST_ARB) && !ax_vld_d && !cfg_vld_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ARB;
            owner_q    <= 1'b0;
            rr_q       <= 1'b1;
            ax_vld_q   <= 1'b0;
            ax_data_q  <= '0;
            ax_type_q  <= '0;
            cfg_vld_q  <= 1'b0;
            cfg_data_q <= '0;
            cfg_type_q <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            idle_q     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                wr_q[i] <= '0;
                rd_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            ax_vld_q   <= ax_vld_d;
            ax_data_q  <= ax_data_d;
            ax_type_q  <= ax_type_d;
            cfg_vld_q  <= cfg_vld_d;
            cfg_data_q <= cfg_data_d;
            cfg_type_q <= cfg_type_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            for (int i = 0; i < 2; i++) begin
                wr_q[i] <= wr_d[i];
                rd_q[i] <= rd_d[i];
            end
        end
    end

    // Storage needs no reset: pointers alone define occupancy
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                dmem_q[i][wr_q[i][AW-1:0]] <= in_data[i];
                tmem_q[i][wr_q[i][AW-1:0]] <= in_type[i];
            end
        end
    end

    assign spk_in_axon_vld  = ax_vld_q;
    assign spk_in_axon_data = ax_data_q;
    assign spk_in_axon_type = ax_type_q;
    assign cfg_vld          = cfg_vld_q;
    assign cfg_data         = cfg_data_q;
    assign cfg_type         = cfg_type_q;
    assign sched_err        = err_q;
    assign spk_cnt          = cnt_q;
    assign sched_idle       = idle_q;

endmodule

// File: tb/tb_axon_sched.sv
// Directed bench for axon_sched: per-cycle vector table plus hand-written
// sequences for FIFO-full, cfg bypass, error and mid-burst reset cases.
module tb_axon_sched;

    localparam logic [2:0] S = 3'b000, D = 3'b001, E = 3'b010, WR = 3'b110, RD = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        in0_vld, in1_vld, in0_rdy, in1_rdy;
    logic [23:0] in0_data, in1_data;
    logic [2:0]  in0_type, in1_type;
    logic        axon_busy;
    logic        av, cv, err, idle;
    logic [23:0] ad, cd;
    logic [2:0]  at, ct;
    logic [15:0] cnt;

    int total = 0;
    int bad   = 0;

    axon_sched dut (
        .clk(clk), .rst(rst),
        .in0_vld(in0_vld), .in0_rdy(in0_rdy), .in0_data(in0_data), .in0_type(in0_type),
        .in1_vld(in1_vld), .in1_rdy(in1_rdy), .in1_data(in1_data), .in1_type(in1_type),
        .axon_busy(axon_busy),
        .spk_in_axon_vld(av), .spk_in_axon_data(ad), .spk_in_axon_type(at),
        .cfg_vld(cv), .cfg_data(cd), .cfg_type(ct),
        .sched_err(err), .spk_cnt(cnt), .sched_idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v0;
        logic [2:0]  t0;
        logic [23:0] d0;
        logic        v1;
        logic [2:0]  t1;
        logic [23:0] d1;
        logic        busy;
        logic        e_av;
        logic [23:0] e_ad;
        logic [2:0]  e_at;
        logic [15:0] e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(input logic r, input logic v0, input logic [2:0] t0,
                                input logic [23:0] d0, input logic v1, input logic [2:0] t1,
                                input logic [23:0] d1, input logic b, input logic eav,
                                input logic [23:0] ead, input logic [2:0] eat,
                                input logic [15:0] ecnt, input logic eerr);
        vec_t v;
        v.rst = r; v.v0 = v0; v.t0 = t0; v.d0 = d0; v.v1 = v1; v.t1 = t1; v.d1 = d1;
        v.busy = b; v.e_av = eav; v.e_ad = ead; v.e_at = eat; v.e_cnt = ecnt; v.e_err = eerr;
        return v;
    endfunction

    function automatic vec_t out_row(input logic b, input logic eav, input logic [23:0] ead,
                                     input logic [2:0] eat, input logic [15:0] ecnt);
        return mk(1'b0, 1'b0, S, 24'h0, 1'b0, S, 24'h0, b, eav, ead, eat, ecnt, 1'b0);
    endfunction

    function automatic vec_t idl(input logic b, input logic [15:0] ecnt);
        return out_row(b, 1'b0, 24'h0, S, ecnt);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive0(input logic v, input logic [2:0] t, input logic [23:0] d);
        in0_vld = v; in0_type = t; in0_data = d;
    endtask

    task automatic drive1(input logic v, input logic [2:0] t, input logic [23:0] d);
        in1_vld = v; in1_type = t; in1_data = d;
    endtask

    initial begin
        rst = 1'b1; axon_busy = 1'b0;
        drive0(1'b0, S, 24'h0);
        drive1(1'b0, S, 24'h0);

        // reset state
        tick();
        chk("rst_av", 32'(av), 32'd0);
        chk("rst_cv", 32'(cv), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_rdy0", 32'(in0_rdy), 32'd0);
        chk("rst_rdy1", 32'(in1_rdy), 32'd0);
        chk("rst_idle", 32'(idle), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rdy0", 32'(in0_rdy), 32'd1);
        chk("post_rdy1", 32'(in1_rdy), 32'd1);
        chk("post_idle", 32'(idle), 32'd1);

        // single spike, round-robin under busy, burst atomicity
        vecs[0]  = mk(1'b0, 1'b1, S, 24'h030201, 1'b0, S, 24'h0, 1'b0, 1'b0, 24'h0, S, 16'd0, 1'b0);
        vecs[1]  = out_row(1'b0, 1'b1, 24'h030201, S, 16'd1);
        vecs[2]  = idl(1'b0, 16'd1);
        vecs[3]  = mk(1'b1, 1'b0, S, 24'h0, 1'b0, S, 24'h0, 1'b0, 1'b0, 24'h0, S, 16'd0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, S, 24'h11, 1'b1, S, 24'h21, 1'b0, 1'b0, 24'h0, S, 16'd0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, S, 24'h12, 1'b1, S, 24'h22, 1'b0, 1'b1, 24'h11, S, 16'd1, 1'b0);
        vecs[6]  = idl(1'b1, 16'd1);
        vecs[7]  = idl(1'b1, 16'd1);
        vecs[8]  = idl(1'b1, 16'd1);
        vecs[9]  = out_row(1'b0, 1'b1, 24'h21, S, 16'd2);
        vecs[10] = idl(1'b1, 16'd2);
        vecs[11] = idl(1'b1, 16'd2);
        vecs[12] = idl(1'b1, 16'd2);
        vecs[13] = out_row(1'b0, 1'b1, 24'h12, S, 16'd3);
        vecs[14] = idl(1'b1, 16'd3);
        vecs[15] = idl(1'b1, 16'd3);
        vecs[16] = idl(1'b1, 16'd3);
        vecs[17] = out_row(1'b0, 1'b1, 24'h22, S, 16'd4);
        vecs[18] = idl(1'b0, 16'd4);
        vecs[19] = mk(1'b0, 1'b0, S, 24'h0, 1'b1, S, 24'h31, 1'b1, 1'b0, 24'h0, S, 16'd4, 1'b0);
        vecs[20] = mk(1'b0, 1'b1, D, 24'hA, 1'b0, S, 24'h0, 1'b1, 1'b0, 24'h0, S, 16'd4, 1'b0);
        vecs[21] = mk(1'b0, 1'b1, D, 24'hB, 1'b0, S, 24'h0, 1'b0, 1'b1, 24'hA, D, 16'd4, 1'b0);
        vecs[22] = mk(1'b0, 1'b1, E, 24'hC, 1'b0, S, 24'h0, 1'b1, 1'b1, 24'hB, D, 16'd4, 1'b0);
        vecs[23] = out_row(1'b1, 1'b1, 24'hC, E, 16'd4);
        vecs[24] = out_row(1'b0, 1'b1, 24'h31, S, 16'd5);
        vecs[25] = idl(1'b0, 16'd5);

        for (int i = 0; i < 26; i++) begin
            rst = vecs[i].rst;
            axon_busy = vecs[i].busy;
            drive0(vecs[i].v0, vecs[i].t0, vecs[i].d0);
            drive1(vecs[i].v1, vecs[i].t1, vecs[i].d1);
            tick();
            chk($sformatf("vec%0d_av", i), 32'(av), 32'(vecs[i].e_av));
            if (vecs[i].e_av) begin
                chk($sformatf("vec%0d_ad", i), 32'(ad), 32'(vecs[i].e_ad));
                chk($sformatf("vec%0d_at", i), 32'(at), 32'(vecs[i].e_at));
            end
            chk($sformatf("vec%0d_cv", i), 32'(cv), 32'd0);
            chk($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].e_err));
        end
        rst = 1'b0;
        drive0(1'b0, S, 24'h0);
        drive1(1'b0, S, 24'h0);

        // in1 FIFO fills under busy, drains in order once released
        axon_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive1(1'b1, S, 24'h40 + 24'(k));
            tick();
        end
        chk("full_rdy1", 32'(in1_rdy), 32'd0);
        chk("full_rdy0", 32'(in0_rdy), 32'd1);
        drive1(1'b1, S, 24'h44);
        tick();
        chk("full_hold_rdy1", 32'(in1_rdy), 32'd0);
        chk("full_hold_av", 32'(av), 32'd0);
        axon_busy = 1'b0;
        tick();
        chk("drain0_av", 32'(av), 32'd1);
        chk("drain0_ad", 32'(ad), 32'h40);
        chk("drain_rdy1", 32'(in1_rdy), 32'd1);
        tick();
        drive1(1'b0, S, 24'h0);
        chk("drain1_ad", 32'(ad), 32'h41);
        for (int k = 2; k < 5; k++) begin
            tick();
            chk($sformatf("drain%0d_av", k), 32'(av), 32'd1);
            chk($sformatf("drain%0d_ad", k), 32'(ad), 32'h40 + 32'(k));
        end
        tick();
        chk("drain_end_av", 32'(av), 32'd0);
        chk("drain_cnt", 32'(cnt), 32'd10);

        // WRITE goes out on cfg even with busy held
        axon_busy = 1'b1;
        drive0(1'b1, WR, 24'h123456);
        tick();
        drive0(1'b0, S, 24'h0);
        chk("wr_cv_early", 32'(cv), 32'd0);
        tick();
        chk("wr_cv", 32'(cv), 32'd1);
        chk("wr_cd", 32'(cd), 32'h123456);
        chk("wr_ct", 32'(ct), 32'(WR));
        chk("wr_av", 32'(av), 32'd0);
        tick();
        chk("wr_cv_after", 32'(cv), 32'd0);

        // rr favours in1, but its SPIKE is blocked so in0 READ goes first
        drive0(1'b1, RD, 24'h52);
        drive1(1'b1, S, 24'h51);
        tick();
        drive0(1'b0, S, 24'h0);
        drive1(1'b0, S, 24'h0);
        tick();
        chk("byp_cv", 32'(cv), 32'd1);
        chk("byp_cd", 32'(cd), 32'h52);
        chk("byp_ct", 32'(ct), 32'(RD));
        chk("byp_av", 32'(av), 32'd0);
        axon_busy = 1'b0;
        tick();
        chk("byp_spk_av", 32'(av), 32'd1);
        chk("byp_spk_ad", 32'(ad), 32'h51);
        chk("byp_cnt", 32'(cnt), 32'd11);

        // orphan DATA_END is dropped and flags an error
        drive1(1'b1, E, 24'h61);
        tick();
        drive1(1'b0, S, 24'h0);
        tick();
        chk("orph_err", 32'(err), 32'd1);
        chk("orph_av", 32'(av), 32'd0);
        chk("orph_cv", 32'(cv), 32'd0);

        // burst on in0, stall on empty owner, then reset mid-burst
        drive0(1'b1, D, 24'h71);
        tick();
        drive0(1'b1, D, 24'h72);
        tick();
        drive0(1'b0, S, 24'h0);
        chk("burst0_ad", 32'(ad), 32'h71);
        chk("burst0_at", 32'(at), 32'(D));
        tick();
        chk("burst1_ad", 32'(ad), 32'h72);
        drive1(1'b1, S, 24'h99);
        tick();
        drive1(1'b0, S, 24'h0);
        chk("stall_av", 32'(av), 32'd0);
        chk("stall_idle", 32'(idle), 32'd0);
        tick();
        chk("stall_hold_av", 32'(av), 32'd0);
        rst = 1'b1;
        tick();
        chk("mrst_av", 32'(av), 32'd0);
        chk("mrst_ad", 32'(ad), 32'd0);
        chk("mrst_cd", 32'(cd), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        chk("mrst_cnt", 32'(cnt), 32'd0);
        chk("mrst_rdy0", 32'(in0_rdy), 32'd0);
        rst = 1'b0;
        tick();
        chk("mrst_rdy0_rel", 32'(in0_rdy), 32'd1);
        chk("mrst_idle", 32'(idle), 32'd1);
        chk("mrst_no_end", 32'(av), 32'd0);
        drive1(1'b1, S, 24'h81);
        tick();
        drive1(1'b0, S, 24'h0);
        tick();
        chk("mrst_arb_av", 32'(av), 32'd1);
        chk("mrst_arb_ad", 32'(ad), 32'h81);
        chk("mrst_arb_cnt", 32'(cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axon_sched.md
Name: axon_sched

Overview:
- Input scheduler placed in front of the axon slide engine in each node.
- Buffers packets from two requesters: in0 (router local port) and in1 (external/host injection). Each requester has its own small FIFO.
- Arbitrates round-robin at packet granularity and keeps DATA..DATA_END bursts atomic.
- Issues to the axon only when axon_busy allows. Diverts WRITE/READ packets to a config port.

Parameters:
- SW, 24, spike/data payload width
- FTW, 3, packet type width
- DEPTH, 4, entries per input FIFO (power of 2, >=2)
- CW, 16, width of spike issue counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in0_vld  in  1  requester 0 packet valid
- in0_rdy  out  1  requester 0 FIFO not full
- in0_data  in  SW  requester 0 payload
- in0_type  in  FTW  requester 0 packet type
- in1_vld  in  1  requester 1 packet valid
- in1_rdy  out  1  requester 1 FIFO not full
- in1_data  in  SW  requester 1 payload
- in1_type  in  FTW  requester 1 packet type
- axon_busy  in  1  axon slide engine busy
- spk_in_axon_vld  out  1  packet to axon, one-cycle pulse
- spk_in_axon_data  out  SW  payload to axon
- spk_in_axon_type  out  FTW  type to axon
- cfg_vld  out  1  WRITE/READ packet pulse
- cfg_data  out  SW  config payload
- cfg_type  out  FTW  config type
- sched_err  out  1  sticky protocol error
- spk_cnt  out  CW  SPIKE packets issued to axon, saturating
- sched_idle  out  1  both FIFOs empty, state ARB, no output pulse this cycle

Behaviour:
- Type encodings: SPIKE=000, DATA=001, DATA_END=010, WRITE=110, READ=111. Codes 011/100/101 are illegal.
- Reset values:
  - All outputs 0, FIFOs empty, state ARB, rr_last=1 (in0 wins the first tie).
  - inX_rdy=0 while rst=1; inX_rdy=!full otherwise.
- Push: a packet is accepted on the edge where inX_vld && inX_rdy. The entry is visible at the FIFO head the next cycle.
- Outputs: all output data/type/vld are registered. Latency from push into an empty FIFO to the output pulse is 2 cycles when the arbiter is free.
- Pop: at most one pop per cycle, across both FIFOs. Push and pop of the same FIFO in one cycle is legal (occupancy unchanged).
- State ARB, per cycle:
  - Candidates are the non-empty FIFOs. If both are candidates, grant the one != rr_last. rr_last updates on every pop.
  - Head SPIKE: pop only if axon_busy==0 this cycle. Next cycle spk_in_axon_vld=1; spk_cnt++ (saturates at all-ones).
  - Head DATA: pop only if axon_busy==0. Forward it and go to BURST with owner=grant.
  - Head WRITE/READ: pop regardless of axon_busy. Next cycle cfg_vld=1 with the data/type.
  - Head DATA_END or illegal code: pop and drop, no output, set sched_err.
  - If the granted head is a SPIKE/DATA blocked by busy and the other FIFO head is WRITE/READ, grant the other FIFO that cycle.
- State BURST:
  - Only the owner FIFO is popped; the other FIFO holds.
  - DATA/DATA_END pops ignore axon_busy, one word per cycle while the owner head is valid. An empty owner FIFO stalls the burst without exiting.
  - Popping DATA_END forwards it and returns to ARB.
  - Owner head of any other type: pop and drop, set sched_err, stay in BURST.
- Gating on busy: axon_busy is sampled combinationally in the decision cycle. The axon raises busy in the same cycle it sees a SPIKE vld, so back-to-back SPIKE issue is inherently prevented.
- sched_err: sticky; cleared only by rst.
- Reset mid-operation (including mid-burst): FIFOs flushed, state ARB, and no DATA_END is synthesised.

Test Plan:
- in0 SPIKE data 0x030201 at cycle 0, busy=0 -> spk_in_axon_vld=1 at cycle 2, data 0x030201, type 000; spk_cnt=1.
- in0 and in1 each push two SPIKEs together; busy high for 3 cycles after each issue -> output order in0,in1,in0,in1. No vld while busy=1.
- in0 pushes DATA 0xA, DATA 0xB, DATA_END 0xC with an in1 SPIKE already queued -> output 0xA,0xB,0xC on consecutive cycles, then the in1 SPIKE.
- busy held 1, in1 pushes 5 SPIKEs -> in1_rdy=0 after 4 accepted. Release busy -> 4 SPIKEs issue in push order and the 5th is accepted.
- busy held 1, in0 WRITE 0x123456 -> cfg_vld=1 two cycles after push with type 110; axon output stays 0.
- Orphan DATA_END on in1 -> dropped, sched_err=1. Then reset asserted mid in0 burst -> all outputs 0, sched_err=0, in0_rdy=0 during reset then 1.
